// File: rtl/rvh_l1d_pkg.sv
// Shared L1D constants and the per-MSHR refill line buffer state encoding.
package rvh_l1d_pkg;

    localparam int L1D_BANK_LINE_DATA_SIZE  = 512;
    localparam int MEM_DATA_WIDTH           = 64;
    localparam int BURST_SIZE               = L1D_BANK_LINE_DATA_SIZE / MEM_DATA_WIDTH;

    localparam int N_MSHR                   = 2;
    localparam int N_MSHR_W                 = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

    localparam int MEMNOC_TID_MASTERID_SIZE = 4;
    localparam int MEMNOC_TID_TID_SIZE      = 4;
    localparam int MEMNOC_TID_SIZE          = MEMNOC_TID_MASTERID_SIZE + MEMNOC_TID_TID_SIZE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DONE    = 2'd2,
        DEALLOC = 2'd3
    } refill_buf_state_e;

endpackage

// File: rtl/rvh_l1d_refill_collector_if.sv
// L2 read-data (R) channel as seen by the L1D refill collector.
interface rvh_l1d_refill_collector_if;
    import rvh_l1d_pkg::*;

    logic                        rvalid;
    logic                        rready;
    logic [MEMNOC_TID_SIZE-1:0]  rid;
    logic [MEM_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;

    modport master (output rvalid, rid, rdata, rresp, rlast, input rready);
    modport slave  (input rvalid, rid, rdata, rresp, rlast, output rready);

endinterface

// File: rtl/rvh_l1d_refill_line_buf.sv
// One MSHR's refill line buffer: beat counter, assembled line, error flag and
// IDLE/FILL/DONE/DEALLOC lifecycle.
module rvh_l1d_refill_line_buf
    import rvh_l1d_pkg::*;
#(
    parameter int BURST_LEN = BURST_SIZE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               beat_fire,
    input  logic [MEM_DATA_WIDTH-1:0]          beat_data,
    input  logic                               beat_err,
    input  logic                               beat_last,
    input  logic                               refill_fire,
    input  logic                               dealloc_fire,
    output refill_buf_state_e                  state,
    output logic [BURST_LEN*MEM_DATA_WIDTH-1:0] line_data,
    output logic                               line_err
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    refill_buf_state_e                  state_reg, state_next;
    logic [CNT_W-1:0]                   cnt_reg, cnt_next;
    logic [BURST_LEN*MEM_DATA_WIDTH-1:0] data_reg, data_next;
    logic                               err_reg, err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        unique case (state_reg)
            IDLE, FILL: begin
                if (beat_fire) begin
                    for (int k = 0; k < BURST_LEN; k++) begin
                        if (cnt_reg == CNT_W'(k)) begin
                            data_next[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = beat_data;
                        end
                    end
                    err_next = err_reg | beat_err;
                    if (beat_last) begin
                        // A short burst leaves the line incomplete, so it is flagged.
                        err_next   = err_reg | beat_err | (cnt_reg != CNT_LAST);
                        cnt_next   = '0;
                        state_next = DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Overlong burst: wrap onto beat 0 and wait for rlast.
                        err_next   = 1'b1;
                        cnt_next   = '0;
                        state_next = FILL;
                    end else begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = FILL;
                    end
                end
            end
            DONE: begin
                if (refill_fire) begin
                    state_next = DEALLOC;
                end
            end
            DEALLOC: begin
                if (dealloc_fire) begin
                    state_next = IDLE;
                    err_next   = 1'b0;
                    data_next  = '0;
                end
            end
        endcase
    end

    assign state     = state_reg;
    assign line_data = data_reg;
    assign line_err  = err_reg;

endmodule

// File: rtl/rvh_l1d_refill_collector.sv
// L1D refill collector: assembles L2 R beats into per-MSHR lines, hands them to
// the MLFB oldest-first, then frees the MSHR. Optional perf counters: RVH_L1D_REFILL_PERF_EN.
module rvh_l1d_refill_collector
    import rvh_l1d_pkg::*;
#(
    parameter int BANK_ID   = 0,
    parameter int BURST_LEN = BURST_SIZE
) (
    input  logic                               clk,
    input  logic                               rst,
    rvh_l1d_refill_collector_if.slave          l2_resp_if,
    output logic                               refill_valid_o,
    input  logic                               refill_ready_i,
    output logic [N_MSHR_W-1:0]                refill_mshr_id_o,
    output logic [L1D_BANK_LINE_DATA_SIZE-1:0] refill_data_o,
    output logic                               refill_err_o,
    output logic                               mshr_dealloc_valid_o,
    output logic [N_MSHR_W-1:0]                mshr_dealloc_idx_o,
    input  logic                               mshr_dealloc_ready_i
`ifdef RVH_L1D_REFILL_PERF_EN
    ,
    output logic [31:0]                        perf_refill_cnt_o,
    output logic [31:0]                        perf_rstall_cnt_o
`endif
);

    localparam logic [MEMNOC_TID_MASTERID_SIZE-1:0] OWN_MASTER = {1'b0, 3'(BANK_ID)};

    logic [MEMNOC_TID_MASTERID_SIZE-1:0] rid_master;
    logic [N_MSHR_W-1:0]                 rid_idx;
    logic                                rid_own;
    logic                                unused_rid_tid_hi;
    logic                                beat_fire_any;

    refill_buf_state_e                   buf_state [N_MSHR];
    logic [L1D_BANK_LINE_DATA_SIZE-1:0]  buf_data  [N_MSHR];
    logic [N_MSHR-1:0]                   buf_err;
    logic [N_MSHR-1:0]                   buf_open, is_done, is_dealloc;
    logic [N_MSHR-1:0]                   beat_fire, complete, refill_fire, dealloc_fire;
    logic [N_MSHR-1:0]                   refill_sel, dealloc_sel;
    // older_reg[i][j] set means buffer i completed its line before buffer j.
    logic [N_MSHR-1:0][N_MSHR-1:0]       older_reg;

    assign rid_master        = l2_resp_if.rid[MEMNOC_TID_TID_SIZE +: MEMNOC_TID_MASTERID_SIZE];
    assign rid_idx           = l2_resp_if.rid[N_MSHR_W-1:0];
    assign unused_rid_tid_hi = ^l2_resp_if.rid[MEMNOC_TID_TID_SIZE-1:N_MSHR_W];
    assign rid_own           = (rid_master == OWN_MASTER);

    // Foreign-master beats are always sunk; own beats wait for a free buffer.
    assign l2_resp_if.rready = !rid_own || buf_open[rid_idx];
    assign beat_fire_any     = l2_resp_if.rvalid && l2_resp_if.rready && rid_own;

    for (genvar gi = 0; gi < N_MSHR; gi++) begin : g_buf
        assign buf_open[gi]     = (buf_state[gi] == IDLE) || (buf_state[gi] == FILL);
        assign is_done[gi]      = (buf_state[gi] == DONE);
        assign is_dealloc[gi]   = (buf_state[gi] == DEALLOC);
        assign beat_fire[gi]    = beat_fire_any && (rid_idx == N_MSHR_W'(gi));
        assign complete[gi]     = beat_fire[gi] && l2_resp_if.rlast;
        assign refill_fire[gi]  = refill_sel[gi] && refill_ready_i;
        assign dealloc_fire[gi] = dealloc_sel[gi] && mshr_dealloc_ready_i;

        rvh_l1d_refill_line_buf #(
            .BURST_LEN (BURST_LEN)
        ) u_line_buf (
            .clk          (clk),
            .rst          (rst),
            .beat_fire    (beat_fire[gi]),
            .beat_data    (l2_resp_if.rdata),
            .beat_err     (l2_resp_if.rresp != 2'b00),
            .beat_last    (l2_resp_if.rlast),
            .refill_fire  (refill_fire[gi]),
            .dealloc_fire (dealloc_fire[gi]),
            .state        (buf_state[gi]),
            .line_data    (buf_data[gi]),
            .line_err     (buf_err[gi])
        );
    end

    // At most one line completes per cycle, so each completion simply becomes
    // the youngest: its own row clears and every other row marks it as younger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older_reg <= '0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                if (complete[i]) begin
                    older_reg[i] <= '0;
                end else begin
                    older_reg[i] <= older_reg[i] | complete;
                end
            end
        end
    end

    // Lines refill in completion order, so the same age relation orders deallocs.
    always_comb begin
        refill_sel  = is_done;
        dealloc_sel = is_dealloc;
        for (int i = 0; i < N_MSHR; i++) begin
            for (int j = 0; j < N_MSHR; j++) begin
                if (older_reg[j][i]) begin
                    refill_sel[i]  = refill_sel[i] && !is_done[j];
                    dealloc_sel[i] = dealloc_sel[i] && !is_dealloc[j];
                end
            end
        end
    end

    always_comb begin
        refill_mshr_id_o   = '0;
        refill_data_o      = '0;
        refill_err_o       = 1'b0;
        mshr_dealloc_idx_o = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (refill_sel[i]) begin
                refill_mshr_id_o = N_MSHR_W'(i);
                refill_data_o    = buf_data[i];
                refill_err_o     = buf_err[i];
            end
            if (dealloc_sel[i]) begin
                mshr_dealloc_idx_o = N_MSHR_W'(i);
            end
        end
    end

    assign refill_valid_o       = |refill_sel;
    assign mshr_dealloc_valid_o = |dealloc_sel;

`ifdef RVH_L1D_REFILL_PERF_EN
    logic [31:0] perf_refill_cnt_reg;
    logic [31:0] perf_rstall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_refill_cnt_reg <= '0;
            perf_rstall_cnt_reg <= '0;
        end else begin
            if (refill_valid_o && refill_ready_i && (perf_refill_cnt_reg != '1)) begin
                perf_refill_cnt_reg <= perf_refill_cnt_reg + 32'd1;
            end
            if (l2_resp_if.rvalid && !l2_resp_if.rready && (perf_rstall_cnt_reg != '1)) begin
                perf_rstall_cnt_reg <= perf_rstall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_refill_cnt_o = perf_refill_cnt_reg;
    assign perf_rstall_cnt_o = perf_rstall_cnt_reg;
`endif

endmodule

// File: tb/tb_rvh_l1d_refill_collector.sv
// Directed self-checking bench for rvh_l1d_refill_collector (BANK_ID 0, two MSHRs).
module tb_rvh_l1d_refill_collector;
    import rvh_l1d_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvh_l1d_refill_collector_if l2_resp_if();

    logic                refill_valid, refill_ready, refill_err;
    logic [N_MSHR_W-1:0] refill_id;
    logic [511:0]        refill_data;
    logic                dealloc_valid, dealloc_ready;
    logic [N_MSHR_W-1:0] dealloc_idx;
`ifdef RVH_L1D_REFILL_PERF_EN
    logic [31:0]         perf_refill_cnt, perf_rstall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rvh_l1d_refill_collector #(.BANK_ID(0)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .l2_resp_if           (l2_resp_if),
        .refill_valid_o       (refill_valid),
        .refill_ready_i       (refill_ready),
        .refill_mshr_id_o     (refill_id),
        .refill_data_o        (refill_data),
        .refill_err_o         (refill_err),
        .mshr_dealloc_valid_o (dealloc_valid),
        .mshr_dealloc_idx_o   (dealloc_idx),
        .mshr_dealloc_ready_i (dealloc_ready)
`ifdef RVH_L1D_REFILL_PERF_EN
        ,
        .perf_refill_cnt_o    (perf_refill_cnt),
        .perf_rstall_cnt_o    (perf_rstall_cnt)
`endif
    );

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
        return l;
    endfunction

    // Presents one beat just after a rising edge; it is taken on the next edge.
    task automatic drive_beat(input logic [7:0] rid, input logic [63:0] d,
                              input logic [1:0] resp, input logic last);
        l2_resp_if.rvalid = 1'b1;
        l2_resp_if.rid    = rid;
        l2_resp_if.rdata  = d;
        l2_resp_if.rresp  = resp;
        l2_resp_if.rlast  = last;
        @(posedge clk); #1;
        l2_resp_if.rvalid = 1'b0;
        l2_resp_if.rresp  = 2'b00;
        l2_resp_if.rlast  = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] rid, input logic [63:0] base,
                             input int nbeats, input int err_beat);
        for (int k = 0; k < nbeats; k++)
            drive_beat(rid, base + 64'(k), (k == err_beat) ? 2'b10 : 2'b00, k == nbeats - 1);
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        refill_ready  = 1'b1;
        dealloc_ready = 1'b1;
        while ((refill_valid || dealloc_valid) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (refill_valid !== 1'b0 || dealloc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: refill_valid=%b dealloc_valid=%b after 20 cycles, required 0/0", name, refill_valid, dealloc_valid);
        end
        refill_ready  = 1'b0;
        dealloc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        l2_resp_if.rvalid = 1'b0; l2_resp_if.rid = 8'h00; l2_resp_if.rdata = '0;
        l2_resp_if.rresp = 2'b00; l2_resp_if.rlast = 1'b0;
        refill_ready = 1'b0; dealloc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (refill_valid !== 1'b0) begin n_fail++; $display("FAIL reset_refill_valid: got %b want 0", refill_valid); end
        n_checks++; if (dealloc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dealloc_valid: got %b want 0", dealloc_valid); end
        n_checks++; if (refill_err !== 1'b0) begin n_fail++; $display("FAIL reset_refill_err: got %b want 0", refill_err); end
        n_checks++; if (refill_data !== '0) begin n_fail++; $display("FAIL reset_refill_data: got %h want 0", refill_data); end
        n_checks++; if (refill_id !== '0 || dealloc_idx !== '0) begin n_fail++; $display("FAIL reset_ids: got %h/%h want 0/0", refill_id, dealloc_idx); end
        n_checks++; if (l2_resp_if.rready !== 1'b1) begin n_fail++; $display("FAIL reset_rready: got %b want 1", l2_resp_if.rready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_line();
        logic [511:0] exp_line = mk_line(64'h1000);
        refill_ready = 1'b1; dealloc_ready = 1'b1;
        send_line(8'h00, 64'h1000, 8, -1);
        n_checks++; if (refill_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", refill_valid); end
        n_checks++; if (refill_id !== 1'b0 || refill_err !== 1'b0) begin n_fail++; $display("FAIL single_id_err: got %h/%b want 0/0", refill_id, refill_err); end
        n_checks++; if (refill_data !== exp_line) begin n_fail++; $display("FAIL single_data: got %h want %h", refill_data, exp_line); end
        n_checks++; if (dealloc_valid !== 1'b0) begin n_fail++; $display("FAIL single_dealloc_early: got %b want 0", dealloc_valid); end
        @(posedge clk); #1;
        n_checks++; if (refill_valid !== 1'b0 || dealloc_valid !== 1'b1 || dealloc_idx !== 1'b0) begin
            n_fail++; $display("FAIL single_dealloc: got refill_valid=%b dealloc_valid=%b idx=%h want 0/1/0", refill_valid, dealloc_valid, dealloc_idx); end
        @(posedge clk); #1;
        n_checks++; if (dealloc_valid !== 1'b0) begin n_fail++; $display("FAIL single_dealloc_done: got %b want 0", dealloc_valid); end
        refill_ready = 1'b0; dealloc_ready = 1'b0;
    endtask

    task automatic test_interleave();
        logic [511:0] exp0 = mk_line(64'h2000);
        logic [511:0] exp1 = mk_line(64'h2100);
        for (int k = 0; k < 8; k++) begin
            drive_beat(8'h01, 64'h2100 + 64'(k), 2'b00, k == 7);
            drive_beat(8'h00, 64'h2000 + 64'(k), 2'b00, k == 7);
        end
        n_checks++; if (refill_valid !== 1'b1 || refill_id !== 1'b1) begin n_fail++; $display("FAIL ilv_first_id: got valid=%b id=%h want 1/1", refill_valid, refill_id); end
        n_checks++; if (refill_data !== exp1) begin n_fail++; $display("FAIL ilv_data1: got %h want %h", refill_data, exp1); end
        refill_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (refill_valid !== 1'b1 || refill_id !== 1'b0 || refill_err !== 1'b0) begin n_fail++; $display("FAIL ilv_second_id: got valid=%b id=%h err=%b want 1/0/0", refill_valid, refill_id, refill_err); end
        n_checks++; if (refill_data !== exp0) begin n_fail++; $display("FAIL ilv_data0: got %h want %h", refill_data, exp0); end
        n_checks++; if (dealloc_valid !== 1'b1 || dealloc_idx !== 1'b1) begin n_fail++; $display("FAIL ilv_dealloc_first: got %b/%h want 1/1", dealloc_valid, dealloc_idx); end
        @(posedge clk); #1;
        refill_ready = 1'b0;
        n_checks++; if (refill_valid !== 1'b0 || dealloc_valid !== 1'b1 || dealloc_idx !== 1'b1) begin
            n_fail++; $display("FAIL ilv_dealloc_older: got refill_valid=%b dealloc=%b/%h want 0/1/1", refill_valid, dealloc_valid, dealloc_idx); end
        dealloc_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (dealloc_valid !== 1'b1 || dealloc_idx !== 1'b0) begin n_fail++; $display("FAIL ilv_dealloc_second: got %b/%h want 1/0", dealloc_valid, dealloc_idx); end
        @(posedge clk); #1;
        n_checks++; if (dealloc_valid !== 1'b0) begin n_fail++; $display("FAIL ilv_dealloc_done: got %b want 0", dealloc_valid); end
        dealloc_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [511:0] exp0 = mk_line(64'h3000);
        logic [511:0] exp1 = mk_line(64'h3100);
        send_line(8'h00, 64'h3000, 8, -1);
        for (int i = 0; i < 5; i++) begin
            l2_resp_if.rvalid = (i == 1) || (i == 2);
            l2_resp_if.rid    = (i == 2) ? 8'h01 : 8'h00;
            l2_resp_if.rdata  = 64'h3100;
            l2_resp_if.rlast  = 1'b0;
            #1;
            n_checks++;
            if (refill_valid !== 1'b1 || refill_id !== 1'b0 || refill_data !== exp0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got valid=%b id=%h data=%h want 1/0/%h", i, refill_valid, refill_id, refill_data, exp0); end
            if (i == 1) begin
                n_checks++; if (l2_resp_if.rready !== 1'b0) begin n_fail++; $display("FAIL bp_rready_same_tid: got %b want 0", l2_resp_if.rready); end
            end
            if (i == 2) begin
                n_checks++; if (l2_resp_if.rready !== 1'b1) begin n_fail++; $display("FAIL bp_rready_other_tid: got %b want 1", l2_resp_if.rready); end
            end
            @(posedge clk); #1;
        end
        l2_resp_if.rvalid = 1'b0;
        for (int k = 1; k < 8; k++) drive_beat(8'h01, 64'h3100 + 64'(k), 2'b00, k == 7);
        refill_ready = 1'b1; dealloc_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (refill_valid !== 1'b1 || refill_id !== 1'b1 || refill_data !== exp1 || refill_err !== 1'b0) begin
            n_fail++; $display("FAIL bp_tid1_line: got valid=%b id=%h err=%b data=%h want 1/1/0/%h", refill_valid, refill_id, refill_err, refill_data, exp1); end
        drain("bp");
    endtask

    task automatic test_error();
        logic [511:0] exp_line;
        send_line(8'h00, 64'h4000, 8, 3);
        n_checks++; if (refill_valid !== 1'b1 || refill_err !== 1'b1) begin n_fail++; $display("FAIL err_rresp: got valid=%b err=%b want 1/1", refill_valid, refill_err); end
        drain("err_rresp");
        send_line(8'h00, 64'h4100, 6, -1);
        n_checks++; if (refill_valid !== 1'b1 || refill_err !== 1'b1) begin n_fail++; $display("FAIL err_short: got valid=%b err=%b want 1/1", refill_valid, refill_err); end
        drain("err_short");
        send_line(8'h00, 64'hA000, 1, -1);
        n_checks++; if (refill_valid !== 1'b1 || refill_err !== 1'b1 || refill_data[63:0] !== 64'hA000) begin
            n_fail++; $display("FAIL err_single_beat: got valid=%b err=%b beat0=%h want 1/1/a000", refill_valid, refill_err, refill_data[63:0]); end
        drain("err_single");
        exp_line = mk_line(64'h9000);
        exp_line[63:0] = 64'h9008;
        send_line(8'h00, 64'h9000, 9, -1);
        n_checks++; if (refill_err !== 1'b1 || refill_data !== exp_line) begin
            n_fail++; $display("FAIL err_overflow: got err=%b data=%h want 1/%h", refill_err, refill_data, exp_line); end
        drain("err_overflow");
        l2_resp_if.rvalid = 1'b1; l2_resp_if.rid = 8'h50; l2_resp_if.rdata = 64'hDEAD; l2_resp_if.rlast = 1'b1;
        #1;
        n_checks++; if (l2_resp_if.rready !== 1'b1) begin n_fail++; $display("FAIL foreign_rready: got %b want 1", l2_resp_if.rready); end
        @(posedge clk); #1;
        l2_resp_if.rvalid = 1'b0; l2_resp_if.rlast = 1'b0;
        n_checks++; if (refill_valid !== 1'b0) begin n_fail++; $display("FAIL foreign_no_line: got %b want 0", refill_valid); end
        exp_line = mk_line(64'h5000);
        send_line(8'h00, 64'h5000, 8, -1);
        n_checks++; if (refill_err !== 1'b0 || refill_data !== exp_line) begin
            n_fail++; $display("FAIL foreign_clean_line: got err=%b data=%h want 0/%h", refill_err, refill_data, exp_line); end
        drain("foreign");
    endtask

    task automatic test_simultaneous();
        logic [511:0] exp_line = mk_line(64'h6100);
        refill_ready = 1'b1;
        send_line(8'h00, 64'h6000, 8, -1);
        @(posedge clk); #1;
        n_checks++; if (dealloc_valid !== 1'b1 || dealloc_idx !== 1'b0) begin n_fail++; $display("FAIL sim_dealloc: got %b/%h want 1/0", dealloc_valid, dealloc_idx); end
        dealloc_ready = 1'b1;
        l2_resp_if.rvalid = 1'b1; l2_resp_if.rid = 8'h00; l2_resp_if.rdata = 64'h6100; l2_resp_if.rlast = 1'b0;
        #1;
        n_checks++; if (l2_resp_if.rready !== 1'b0) begin n_fail++; $display("FAIL sim_rready_blocked: got %b want 0", l2_resp_if.rready); end
        @(posedge clk); #1;
        dealloc_ready = 1'b0;
        n_checks++; if (dealloc_valid !== 1'b0 || l2_resp_if.rready !== 1'b1) begin
            n_fail++; $display("FAIL sim_next_cycle: got dealloc_valid=%b rready=%b want 0/1", dealloc_valid, l2_resp_if.rready); end
        @(posedge clk); #1;
        l2_resp_if.rvalid = 1'b0;
        for (int k = 1; k < 8; k++) drive_beat(8'h00, 64'h6100 + 64'(k), 2'b00, k == 7);
        n_checks++; if (refill_valid !== 1'b1 || refill_err !== 1'b0 || refill_data !== exp_line) begin
            n_fail++; $display("FAIL sim_fresh_line: got valid=%b err=%b data=%h want 1/0/%h", refill_valid, refill_err, refill_data, exp_line); end
        drain("sim");
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp_line = mk_line(64'h8000);
        for (int k = 0; k < 4; k++) drive_beat(8'h00, 64'h7000 + 64'(k), 2'b01, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++; if (refill_valid !== 1'b0 || dealloc_valid !== 1'b0 || refill_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_valids: got %b/%b/%b want 0/0/0", refill_valid, dealloc_valid, refill_err); end
        n_checks++; if (refill_data !== '0 || refill_id !== '0 || dealloc_idx !== '0 || l2_resp_if.rready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_payload: got data=%h id=%h idx=%h rready=%b want 0/0/0/1", refill_data, refill_id, dealloc_idx, l2_resp_if.rready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_line(8'h00, 64'h8000, 8, -1);
        n_checks++; if (refill_valid !== 1'b1 || refill_err !== 1'b0 || refill_data !== exp_line) begin
            n_fail++; $display("FAIL rstmid_clean_line: got valid=%b err=%b data=%h want 1/0/%h", refill_valid, refill_err, refill_data, exp_line); end
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_interleave();
        test_backpressure();
        test_error();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
